// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares the single Memory port between two requesters. Requester 0 is the
// SAM datapath, requester 1 a loader/DMA master. One transaction at a time;
// ties alternate round-robin, and a watchdog aborts transfers whose WAIT
// never drops.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   rN_req/rw/addr/wdata       request level (held until ack), 1=read, address, write data
//   rN_ack, rN_err             one-cycle completion pulse, timeout flag with ack
//   rN_rdata                   read data, updated in the ack cycle and held
//   mem_req/rw/addr/wdata      Memory REQUEST, RW, ADDRESS_BUS, write data
//   mem_rdata, mem_wait        Memory read data, busy (low = transfer complete)
//   busy                       arbiter not idle
//   grant_id                   requester currently or last served
module mem_port_arbiter #(
    parameter int unsigned AW      = 16,
    parameter int unsigned DW      = 16,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          r0_req,
    input  logic          r0_rw,
    input  logic [AW-1:0] r0_addr,
    input  logic [DW-1:0] r0_wdata,
    input  logic          r1_req,
    input  logic          r1_rw,
    input  logic [AW-1:0] r1_addr,
    input  logic [DW-1:0] r1_wdata,
    output logic          r0_ack,
    output logic          r0_err,
    output logic [DW-1:0] r0_rdata,
    output logic          r1_ack,
    output logic          r1_err,
    output logic [DW-1:0] r1_rdata,
    output logic          mem_req,
    output logic          mem_rw,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_wait,
    output logic          busy,
    output logic          grant_id
);

    // Counter only needs to reach TIMEOUT-1 before the transfer is aborted.
    localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Command latched onto the Memory port for the duration of a transfer.
    typedef struct packed {
        logic          rw;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } mem_cmd_t;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    mem_cmd_t        cmd_q, cmd_d;
    logic            mem_req_q, mem_req_d;
    logic            grant_q, grant_d;
    logic            last_q, last_d;
    logic            busy_q, busy_d;
    logic            ack0_q, ack0_d, ack1_q, ack1_d;
    logic            err0_q, err0_d, err1_q, err1_d;
    logic [DW-1:0]   rdata0_q, rdata0_d, rdata1_q, rdata1_d;

    logic            any_req_c;
    logic            win_c;

    // Lone requester wins; on a tie the one not served last wins.
    assign any_req_c = r0_req | r1_req;
    assign win_c     = (r0_req && r1_req) ? ~last_q : r1_req;

    // State register and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            cmd_q     <= '{rw: 1'b1, addr: '0, wdata: '0};
            mem_req_q <= 1'b0;
            grant_q   <= 1'b0;
            last_q    <= 1'b1;
            busy_q    <= 1'b0;
            ack0_q    <= 1'b0;
            ack1_q    <= 1'b0;
            err0_q    <= 1'b0;
            err1_q    <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cmd_q     <= cmd_d;
            mem_req_q <= mem_req_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            busy_q    <= busy_d;
            ack0_q    <= ack0_d;
            ack1_q    <= ack1_d;
            err0_q    <= err0_d;
            err1_q    <= err1_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cmd_d     = cmd_q;
        mem_req_d = mem_req_q;
        grant_d   = grant_q;
        last_d    = last_q;
        busy_d    = busy_q;
        ack0_d    = 1'b0;
        ack1_d    = 1'b0;
        err0_d    = 1'b0;
        err1_d    = 1'b0;
        rdata0_d  = rdata0_q;
        rdata1_d  = rdata1_q;

        case (state_q)
            ST_IDLE: begin
                if (any_req_c) begin
                    if (win_c) begin
                        cmd_d = '{rw: r1_rw, addr: r1_addr, wdata: r1_wdata};
                    end else begin
                        cmd_d = '{rw: r0_rw, addr: r0_addr, wdata: r0_wdata};
                    end
                    mem_req_d = 1'b1;
                    grant_d   = win_c;
                    last_d    = win_c;
                    busy_d    = 1'b1;
                    cnt_d     = '0;
                    state_d   = ST_XFER;
                end
            end

            ST_XFER: begin
                cnt_d = cnt_q + CW'(1);
                // First XFER edge gives Memory a cycle to raise WAIT.
                if ((cnt_q != '0) && !mem_wait) begin
                    if (cmd_q.rw) begin
                        if (grant_q) rdata1_d = mem_rdata;
                        else         rdata0_d = mem_rdata;
                    end
                    mem_req_d = 1'b0;
                    ack0_d    = ~grant_q;
                    ack1_d    = grant_q;
                    state_d   = ST_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    // Watchdog abort: report error with zeroed read data.
                    if (grant_q) rdata1_d = '0;
                    else         rdata0_d = '0;
                    mem_req_d = 1'b0;
                    ack0_d    = ~grant_q;
                    ack1_d    = grant_q;
                    err0_d    = ~grant_q;
                    err1_d    = grant_q;
                    state_d   = ST_DONE;
                end
            end

            ST_DONE: begin
                // Ack cycle; a fresh grant can only come from IDLE.
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end

            default: begin
                mem_req_d = 1'b0;
                busy_d    = 1'b0;
                state_d   = ST_IDLE;
            end
        endcase
    end

    assign r0_ack    = ack0_q;
    assign r1_ack    = ack1_q;
    assign r0_err    = err0_q;
    assign r1_err    = err1_q;
    assign r0_rdata  = rdata0_q;
    assign r1_rdata  = rdata1_q;
    assign mem_req   = mem_req_q;
    assign mem_rw    = cmd_q.rw;
    assign mem_addr  = cmd_q.addr;
    assign mem_wdata = cmd_q.wdata;
    assign busy      = busy_q;
    assign grant_id  = grant_q;

endmodule
